// File: rtl/oclib_ready_valid_credit_rx.sv
// oclib_ready_valid_credit_rx
// Receive end of a credit-flow link. Words pushed without backpressure are
// buffered in a Depth-entry circular FIFO and re-presented as a ready/valid
// stream; one credit pulse is returned per word consumed downstream.
// Optional build macro: OCLIB_CREDIT_RX_OVERFLOW_CHECK_EN enables the sticky
// overflowError flag and a simulation assertion on push-while-full.
module oclib_ready_valid_credit_rx #(
  parameter int Width      = 32,
  parameter int Depth      = 8,
  parameter int LevelWidth = $clog2(Depth + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [Width-1:0]      inData,
  input  logic                  inValid,
  output logic                  creditReturn,
  output logic [Width-1:0]      outData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [LevelWidth-1:0] fillLevel,
  output logic                  overflowError
);

  localparam int                    PtrWidth  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrWidth-1:0]   LastPtr   = PtrWidth'(Depth - 1);
  localparam logic [LevelWidth-1:0] FullLevel = LevelWidth'(Depth);

  logic [Width-1:0]      mem_q [Depth];
  logic [Width-1:0]      mem_d [Depth];
  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LevelWidth-1:0] level_q, level_d;
  logic                  credit_q, credit_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Full/empty come from registered occupancy only, so a pop in the same
  // cycle never makes room for a push into a full FIFO.
  assign full  = (level_q == FullLevel);
  assign empty = (level_q == '0);
  assign push  = inValid && !full;
  assign pop   = !empty && outReady;

  // Next-state for storage, pointers, occupancy and the credit pulse.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    credit_d = pop;
    if (push) begin
      mem_d[wr_ptr_q] = inData;
      wr_ptr_d        = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrWidth'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrWidth'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LevelWidth'(1);
      2'b01:   level_d = level_q - LevelWidth'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state with synchronous reset; flushing drops buffered words.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      credit_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      credit_q <= credit_d;
    end
  end

  // Storage array is not reset; contents are only visible while outValid.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign outData   = mem_q[rd_ptr_q];
  assign outValid  = !empty;
  assign fillLevel = level_q;
  // A pulse already registered when reset arrives belongs to a flushed
  // session; the transmitter is reset together with us, so hide it.
  assign creditReturn = credit_q && !reset;

`ifdef OCLIB_CREDIT_RX_OVERFLOW_CHECK_EN
  logic ovf_q, ovf_d;

  // Sticky flag: any push attempt while full, regardless of a same-cycle pop.
  always_comb begin
    ovf_d = ovf_q || (inValid && full);
  end

  // Overflow flag register, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflowError = ovf_q;

  a_no_overflow : assert property (@(posedge clock) disable iff (reset) !(inValid && full))
    else $warning("credit overflow");
`else
  assign overflowError = 1'b0;
`endif

endmodule

// File: tb/tb_oclib_ready_valid_credit_rx.sv
// Testbench for oclib_ready_valid_credit_rx (Width=8, Depth=4).
module tb_oclib_ready_valid_credit_rx;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int LW = $clog2(D + 1);

`ifdef OCLIB_CREDIT_RX_OVERFLOW_CHECK_EN
  localparam logic OvfEn = 1'b1;
`else
  localparam logic OvfEn = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic [W-1:0]  inData;
  logic          inValid;
  logic          creditReturn;
  logic [W-1:0]  outData;
  logic          outValid;
  logic          outReady;
  logic [LW-1:0] fillLevel;
  logic          overflowError;

  int n_vec = 0;
  int n_err = 0;
  int credit_cnt = 0;

  always #5 clock = ~clock;

  oclib_ready_valid_credit_rx #(.Width(W), .Depth(D)) dut (
    .clock        (clock),
    .reset        (reset),
    .inData       (inData),
    .inValid      (inValid),
    .creditReturn (creditReturn),
    .outData      (outData),
    .outValid     (outValid),
    .outReady     (outReady),
    .fillLevel    (fillLevel),
    .overflowError(overflowError)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    if (creditReturn === 1'b1) credit_cnt++;
  endtask

  task automatic drive(input logic r, input logic v, input logic [W-1:0] d, input logic rdy);
    reset    = r;
    inValid  = v;
    inData   = d;
    outReady = rdy;
  endtask

  typedef struct packed {
    logic         rst;
    logic         v;
    logic [W-1:0] d;
    logic         r;
    logic         ev;
    logic [W-1:0] ed;
    logic [2:0]   el;
    logic         ec;
  } vec_t;

  vec_t tbl [18];

  logic [W-1:0] q [$];

  initial begin
    //           rst v  d      r   ev ed     el ec
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 3'd1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 3'd1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 8'hA0, 1'b0, 1'b1, 8'hA0, 3'd1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 8'hA0, 3'd2, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 8'hA0, 3'd3, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 8'hA0, 3'd4, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA1, 3'd3, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA2, 3'd2, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA3, 3'd1, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 8'h55, 3'd1, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 8'h56, 1'b1, 1'b1, 8'h56, 3'd1, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};

    drive(1'b1, 1'b0, '0, 1'b0);
    step();

    // Table-driven basic sequence.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].r);
      step();
      chk($sformatf("tbl%0d_valid", i), outValid, tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), outData, tbl[i].ed);
      chk($sformatf("tbl%0d_level", i), fillLevel, tbl[i].el);
      chk($sformatf("tbl%0d_credit", i), creditReturn, tbl[i].ec);
      chk($sformatf("tbl%0d_ovf", i), overflowError, 1'b0);
    end

    // Continuous push and pop, 20 words.
    credit_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 8'(8'h60 + i), 1'b1);
      step();
      chk($sformatf("stream%0d_valid", i), outValid, 1'b1);
      chk($sformatf("stream%0d_data", i), outData, 8'(8'h60 + i));
      chk($sformatf("stream%0d_level", i), fillLevel, 1);
      chk($sformatf("stream%0d_credit", i), creditReturn, (i > 0) ? 1 : 0);
    end
    drive(1'b0, 1'b0, '0, 1'b1);
    step();
    chk("stream_drain_valid", outValid, 1'b0);
    chk("stream_drain_credit", creditReturn, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0);
    step();
    chk("stream_credit_total", credit_cnt, 20);

    // Overflow: fill to Depth, then push while popping.
    drive(1'b1, 1'b0, '0, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 8'(8'hB0 + i), 1'b0);
      step();
    end
    chk("ovf_full_level", fillLevel, 4);
    drive(1'b0, 1'b1, 8'hEE, 1'b1);
    step();
    chk("ovf_level", fillLevel, 3);
    chk("ovf_head", outData, 8'hB1);
    chk("ovf_credit", creditReturn, 1'b1);
    chk("ovf_flag_set", overflowError, OvfEn);
    drive(1'b0, 1'b0, '0, 1'b0);
    step();
    chk("ovf_flag_hold", overflowError, OvfEn);
    chk("ovf_level_hold", fillLevel, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ovf_drain%0d_data", i), outData, 8'(8'hB1 + i));
      drive(1'b0, 1'b0, '0, 1'b1);
      step();
    end
    chk("ovf_drained_valid", outValid, 1'b0);
    chk("ovf_drained_level", fillLevel, 0);
    chk("ovf_flag_sticky", overflowError, OvfEn);

    // Reset mid-operation with a credit pulse pending.
    drive(1'b1, 1'b0, '0, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
      step();
    end
    drive(1'b0, 1'b0, '0, 1'b1);
    step();
    chk("rst_pre_level", fillLevel, 3);
    drive(1'b1, 1'b0, '0, 1'b0);
    #1;
    chk("rst_credit_suppressed", creditReturn, 1'b0);
    step();
    chk("rst_level", fillLevel, 0);
    chk("rst_valid", outValid, 1'b0);
    chk("rst_ovf", overflowError, 1'b0);
    chk("rst_credit", creditReturn, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    step();
    chk("rst_after_credit", creditReturn, 1'b0);
    chk("rst_after_level", fillLevel, 0);

    // Random stall against a queue model with a 4-credit transmitter.
    begin
      int credits = 4;
      int sent = 0;
      int cyc = 0;
      logic [W-1:0] seq = '0;
      logic did_pop;
      credit_cnt = 0;
      q.delete();
      while (cyc < 20000 && (sent < 1000 || q.size() > 0)) begin
        inValid  = (credits > 0) && (sent < 1000) && ($urandom_range(0, 3) != 0);
        inData   = seq;
        outReady = 1'($urandom_range(0, 1));
        step();
        did_pop = (q.size() > 0) && outReady;
        if (did_pop) void'(q.pop_front());
        if (inValid) begin
          if (q.size() + (did_pop ? 1 : 0) < D) q.push_back(seq);
          seq++;
          sent++;
          credits--;
        end
        chk("rand_valid", outValid, (q.size() > 0) ? 1 : 0);
        if (q.size() > 0) chk("rand_data", outData, q[0]);
        chk("rand_level", fillLevel, q.size());
        chk("rand_credit", creditReturn, did_pop);
        if (creditReturn === 1'b1) credits++;
        cyc++;
      end
      chk("rand_completed", ((sent == 1000) && (q.size() == 0)) ? 1 : 0, 1);
      drive(1'b0, 1'b0, '0, 1'b0);
      step();
      chk("rand_credit_total", credit_cnt, 1000);
      chk("rand_ovf_clear", overflowError, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/oclib_ready_valid_credit_rx.md
# oclib_ready_valid_credit_rx

Receive end of a credit-flow link: accepts pushed words (valid only, no ready) from a deep or retimed ready-less path and re-presents them as a ready/valid stream. The block buffers them in a Depth-entry FIFO and returns one credit pulse per word consumed downstream. It sits at the far end of long inter-region or inter-die paths where a per-stage ready/valid retime is too costly. The transmitter owns Depth credits after reset.

## Interface
- Width, 32: data width in bits, >= 1.
- Depth, 8: FIFO entries, >= 2. It equals the credit count the transmitter holds after reset. Any integer is allowed, not only powers of two.
- LevelWidth, $clog2(Depth+1): width of fillLevel. Derived; do not override.

Ports:
- clock  input  1  single clock for all logic.
- reset  input  1  synchronous, active-high; samples on the rising clock edge.
- inData  input  Width  pushed word.
- inValid  input  1  push strobe. There is no ready; the transmitter guarantees it holds a credit.
- creditReturn  output  1  one-cycle pulse, one per word popped.
- outData  output  Width  head-of-FIFO word.
- outValid  output  1  FIFO non-empty.
- outReady  input  1  downstream accept.
- fillLevel  output  LevelWidth  current occupancy, 0..Depth.
- overflowError  output  1  sticky push-while-full flag. Only active when the configuration macro is defined.

## Operation
- Push: the write is taken when inValid is high at a rising edge and the FIFO is not full. "Full" is evaluated from the state at the start of the cycle.
- Pop: occurs when outValid && outReady.
- Simultaneous push and pop:
  - Not full: both occur, and fillLevel is unchanged.
  - Full: the push is dropped even though a pop occurs the same cycle. This is an overflow.
  - Empty: the push is written. No pop occurs, because outValid is low.
- Storage is a circular buffer with read and write pointers in 0..Depth-1. Each pointer wraps from Depth-1 to 0 by compare, not by power-of-two masking.
- fillLevel is a registered counter:
  - +1 on a push only.
  - -1 on a pop only.
  - Unchanged on both or neither.
  - It never exceeds Depth and never underflows.
- outData and outValid hold stable while outValid && !outReady.
- creditReturn is registered: a pop in cycle N produces a pulse in cycle N+1.
  - Back-to-back pops give back-to-back pulses.
  - Total pulses always equal total pops since reset.
- Reset mid-operation:
  - The FIFO is flushed and fillLevel goes to 0.
  - No credits are returned for flushed words.
  - A creditReturn pulse pending for the reset cycle is suppressed.
  - The transmitter must be reset in the same cycle.

## Timing
- Reset values: outValid=0, creditReturn=0, fillLevel=0, overflowError=0. outData is don't-care while outValid=0.
- Push-to-out latency is 1 cycle: a word pushed at edge N into an empty FIFO shows outValid=1 and outData=word after edge N, with no combinational path from inValid to outValid.
- Pop-to-credit latency is 1 cycle. The minimum round trip is 2 cycles plus the link latency. The transmitter sustains full rate if Depth >= 2 + round-trip link latency.
- outReady to outValid has no combinational dependency. outReady combinationally affects only the next-state logic.
- Throughput: 1 word per cycle in each direction when not empty and not full.

## Configuration
- OCLIB_CREDIT_RX_OVERFLOW_CHECK_EN, when defined:
  - A push while full sets overflowError on the next edge.
  - overflowError stays set until reset.
  - A simulation-only assertion fires with the message "credit overflow".
- When undefined:
  - A push while full is silently dropped.
  - overflowError is tied to 0.
  - No overflow-detection logic is generated.
- The FIFO datapath is identical in both builds.

## Test plan
Bench setup: Width=8, Depth=4, macro defined unless noted.
- Reset, then push 0x11 with outReady=0: outValid=1 with outData=0x11 one cycle later, fillLevel=1, creditReturn stays 0.
- Push 0xA0..0xA3 back-to-back with outReady=0, then raise outReady for 4 cycles:
  - fillLevel reaches 4.
  - Pops return 0xA0..0xA3 in order.
  - Exactly 4 creditReturn pulses, each one cycle after its pop.
  - fillLevel ends at 0 and outValid=0.
- Continuous push and pop for 20 words with outReady=1: every word emerges 1 cycle after its push, fillLevel stays 1, 20 credit pulses are seen, and the pointers wrap 5 times.
- Overflow:
  - Sequence: fill to 4, then push 0xEE while popping the same cycle.
  - Required response: 0xEE is dropped, overflowError=1 next cycle and stays 1, and the three older words are intact.
  - Repeat in a build without the macro: 0xEE is dropped and overflowError=0.
- Reset mid-operation: with fillLevel=3 and a pop in the cycle before reset, assert reset. Required response: no creditReturn pulse, and fillLevel=0, outValid=0, overflowError=0.
- Random stall: random outReady at 50% over 1000 words with a model transmitter holding 4 credits. Required response: data order is preserved, overflowError is never set, and credits returned equal 1000.
